// File: rtl/pid_sched_pkg.sv
`default_nettype none
// pid_sched_pkg: shared FSM state type and channel-selection helper for pid_scheduler (rev 1.0).
package pid_sched_pkg;

  localparam int MAX_CH = 32;
  localparam int MAX_CW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic              found;
    logic [MAX_CW-1:0] idx;
  } sel_t;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  function automatic sel_t lowest_set(input logic [MAX_CH-1:0] mask);
    sel_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.idx   = MAX_CW'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/period_ticker.sv
`default_nettype none
// period_ticker: one-cycle tick every period+1 cycles while enabled (rev 1.0).
module period_ticker #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic             w_hit;

  // >= rather than == so a live period decrease below the count ticks at once.
  assign w_hit = enable && (r_count >= period);
  assign tick  = w_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!enable || w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pid_scheduler.sv
`default_nettype none
// pid_scheduler: shares one PID core across NCH channels, one request per enabled channel per frame (rev 1.0).
module pid_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NCH   = 5,
  parameter int CW    = $clog2(NCH),
  parameter int W     = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [DIV_W-1:0] period,
  output logic             req_valid,
  output logic [CW-1:0]    req_ch,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic [W-1:0]     rsp_data,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_strobe,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  state_t           r_state, w_state_nxt;
  logic [NCH-1:0]   r_pending, w_pending_nxt;
  logic [CW-1:0]    r_req_ch, w_req_ch_nxt;
  logic [NCH*W-1:0] r_out_data;
  logic [NCH-1:0]   r_strobe;
  logic             r_overrun;
  logic             w_tick;
  logic             w_rsp_take;
  logic [NCH-1:0]   w_remaining;
  sel_t             w_first, w_next;

  period_ticker #(.DIV_W(DIV_W)) u_ticker (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .period  (period),
    .tick    (w_tick)
  );

  assign w_rsp_take  = (r_state == WAIT) && rsp_valid;
  assign w_remaining = r_pending & ~(NCH'(1) << r_req_ch);
  assign w_first     = lowest_set(MAX_CH'(ch_enable));
  assign w_next      = lowest_set(MAX_CH'(w_remaining));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_req_ch  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_req_ch  <= w_req_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_req_ch_nxt  = r_req_ch;
    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_pending_nxt = ch_enable;
          if (w_first.found) begin
            w_state_nxt  = ISSUE;
            w_req_ch_nxt = CW'(w_first.idx);
          end
        end
      end
      ISSUE: begin
        if (!enable) begin
          w_state_nxt   = IDLE;
          w_pending_nxt = '0;
        end else if (req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // The outstanding transaction always completes; enable only gates what follows.
        if (rsp_valid) begin
          if (enable && w_next.found) begin
            w_state_nxt   = ISSUE;
            w_pending_nxt = w_remaining;
            w_req_ch_nxt  = CW'(w_next.idx);
          end else begin
            w_state_nxt   = IDLE;
            w_pending_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data <= '0;
      r_strobe   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_strobe <= '0;
      if (w_rsp_take) begin
        r_out_data[r_req_ch*W +: W] <= rsp_data;
        r_strobe                    <= NCH'(1) << r_req_ch;
      end
      if (w_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign req_valid  = (r_state == ISSUE) && enable;
  assign req_ch     = r_req_ch;
  assign out_data   = r_out_data;
  assign out_strobe = r_strobe;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pid_scheduler.sv
`default_nettype none
// tb_pid_scheduler: scoreboard bench for pid_scheduler with a modelled PID core responder.
module tb_pid_scheduler;

  localparam int NCH = 5;
  localparam int CW  = 3;
  localparam int W   = 16;

  logic           clk;
  logic           reset_n;
  logic           enable;
  logic [NCH-1:0] ch_enable;
  logic [15:0]    period;
  logic           req_valid;
  logic [CW-1:0]  req_ch;
  logic           req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0] out_strobe;
  logic           busy;
  logic           overrun;
  logic           clr_overrun;

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rsp_q[$];

  int n_checks  = 0;
  int n_errors  = 0;
  int n_strobes = 0;

  int ready_delay = 0;
  int rsp_delay   = 0;
  bit core_on     = 1'b1;
  int stray_req   = 0;

  pid_scheduler #(.NCH(NCH), .CW(CW), .W(W), .DIV_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .ch_enable   (ch_enable),
    .period      (period),
    .req_valid   (req_valid),
    .req_ch      (req_ch),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .out_data    (out_data),
    .out_strobe  (out_strobe),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
    rsp_q.push_back(data);
  endtask

  task automatic wait_busy(input logic val, input int limit, output int n);
    n = 0;
    while (busy !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy_bound", busy, val);
  endtask

  // Modelled PID core: ready after ready_delay cycles, result rsp_delay cycles after handshake.
  initial begin
    int          phase;
    int          cnt;
    int          stray_done;
    logic [CW-1:0] hold_ch;
    phase = 0; cnt = 0; stray_done = 0; hold_ch = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      if (!reset_n) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (stray_req != stray_done) begin
              stray_done = stray_req;
              rsp_valid  = 1'b1;
              rsp_data   = 16'hBEEF;
            end else if (core_on && req_valid) begin
              hold_ch = req_ch;
              if (ready_delay == 0) begin
                req_ready = 1'b1;
                phase = 2;
              end else begin
                cnt = ready_delay;
                phase = 1;
              end
            end
          end
          1: begin
            check("bp_req_valid", req_valid, 1'b1);
            check("bp_req_ch", req_ch, hold_ch);
            cnt--;
            if (cnt == 0) begin
              req_ready = 1'b1;
              phase = 2;
            end
          end
          2, 3: begin
            if (phase == 2) cnt = rsp_delay;
            else cnt--;
            if (cnt == 0) begin
              rsp_valid = 1'b1;
              rsp_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hDEAD;
              phase = 0;
            end else begin
              phase = 3;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_strobe != '0) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", out_strobe, '0);
        end else begin
          e = exp_q.pop_front();
          check("strobe", out_strobe, NCH'(1) << e.ch);
          check("out_slice", out_data[e.ch*W +: W], e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, n1, n2, s0, cnt_act;
    logic [NCH*W-1:0] exp_data;

    reset_n = 1'b0; enable = 1'b0; ch_enable = '0; period = 16'd9; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_ch", req_ch, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_strobe", out_strobe, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame: ch0, ch2, ch4 twice, frame every 10 cycles.
    ch_enable = 5'b10101;
    push(0, 16'h1A00); push(2, 16'h1A02); push(4, 16'h1A04);
    push(0, 16'h2B00); push(2, 16'h2B02); push(4, 16'h2B04);
    enable = 1'b1;
    wait_busy(1'b1, 40, n);
    check("tick_latency", n, 10);
    wait_busy(1'b0, 40, n1);
    check("frame_len_3ch", n1, 6);
    wait_busy(1'b1, 40, n2);
    check("frame_period", n1 + n2, 10);
    wait_busy(1'b0, 40, n);
    enable = 1'b0;
    @(negedge clk);
    check("basic_q_empty", exp_q.size(), 0);
    exp_data = '0;
    exp_data[0*W +: W] = 16'h2B00;
    exp_data[2*W +: W] = 16'h2B02;
    exp_data[4*W +: W] = 16'h2B04;
    check("basic_out_data", out_data, exp_data);
    check("basic_no_overrun", overrun, 1'b0);

    // Backpressure: ready held low 4 cycles on ch1.
    ch_enable = 5'b00010;
    ready_delay = 4;
    push(1, 16'hC0C1);
    s0 = n_strobes;
    enable = 1'b1;
    wait_busy(1'b1, 40, n);
    wait_busy(1'b0, 40, n);
    enable = 1'b0;
    @(negedge clk);
    ready_delay = 0;
    check("bp_one_txn", n_strobes - s0, 1);
    exp_data[1*W +: W] = 16'hC0C1;
    check("bp_out_data", out_data, exp_data);

    // Overrun: 5-channel frame cannot fit a 3-cycle period.
    period = 16'd2;
    ch_enable = 5'b11111;
    for (int i = 0; i < NCH; i++) push(i, 16'hD000 + 16'(i));
    enable = 1'b1;
    wait_busy(1'b1, 40, n);
    wait_busy(1'b0, 40, n);
    enable = 1'b0;
    @(negedge clk);
    check("overrun_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_cleared", overrun, 1'b0);

    // Clear coinciding with a new overrun: set wins.
    for (int i = 0; i < NCH; i++) push(i, 16'hE000 + 16'(i));
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("overrun_pre", overrun, 1'b0);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_set_wins", overrun, 1'b1);
    wait_busy(1'b0, 40, n);
    enable = 1'b0;
    @(negedge clk);
    check("overrun_q_empty", exp_q.size(), 0);

    // Disable while waiting on ch1: result still latched, nothing further issued.
    period = 16'd9;
    ch_enable = 5'b00110;
    rsp_delay = 3;
    push(1, 16'hF1F1);
    s0 = n_strobes;
    enable = 1'b1;
    wait_busy(1'b1, 40, n);
    @(negedge clk);
    check("dis_in_wait_busy", busy, 1'b1);
    check("dis_in_wait_req", req_valid, 1'b0);
    enable = 1'b0;
    wait_busy(1'b0, 20, n);
    @(negedge clk);
    rsp_delay = 0;
    check("dis_one_txn", n_strobes - s0, 1);
    check("dis_ch1_data", out_data[1*W +: W], 16'hF1F1);
    cnt_act = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (req_valid || busy) cnt_act++;
    end
    check("dis_no_activity", cnt_act, 0);
    check("dis_count_zero", dut.u_ticker.r_count, '0);

    // Asynchronous reset while a request is being presented.
    core_on = 1'b0;
    period = 16'd3;
    ch_enable = 5'b00001;
    enable = 1'b1;
    n = 0;
    while (!req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_req_seen", req_valid, 1'b1);
    check("ar_pre_overrun", overrun, 1'b1);
    check("ar_pre_data_nz", (out_data != '0), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_req_valid", req_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_out_data", out_data, '0);
    check("ar_overrun", overrun, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
    core_on = 1'b1;
    @(negedge clk);

    // Empty mask: ticks every cycle but nothing is issued.
    period = 16'd0;
    ch_enable = '0;
    enable = 1'b1;
    cnt_act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid || busy) cnt_act++;
    end
    check("empty_no_activity", cnt_act, 0);

    // Stray response in IDLE is ignored.
    s0 = n_strobes;
    stray_req++;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    check("stray_no_strobe", n_strobes - s0, 0);
    check("stray_out_data", out_data, '0);
    check("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pid_scheduler.md
# pid_scheduler

Time-multiplexes one shared PID compute core across NCH actuator channels. A programmable sample-period ticker starts each control frame. The block then issues one request per enabled channel, in ascending index order, over a valid/ready handshake, and latches each returned result into a per-channel output register with an update strobe. It sits between the register/configuration logic and the single PID datapath instance, so one core serves every finger channel.

## Interface
- NCH, 5, number of channels (≥2)
- CW, $clog2(NCH), channel index width
- W, 16, result data width
- DIV_W, 16, sample-period counter width
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global scheduler enable
- ch_enable  in  NCH  per-channel enable mask
- period  in  DIV_W  frame period in clk cycles, minus 1
- req_valid  out  1  request to PID core
- req_ch  out  CW  channel index of the request
- req_ready  in  1  core accepts request
- rsp_valid  in  1  core result valid, one cycle
- rsp_data  in  W  core result for the outstanding channel
- out_data  out  NCH*W  packed per-channel results; channel i at [i*W +: W]
- out_strobe  out  NCH  one-cycle pulse on the channel whose result updated
- busy  out  1  frame in progress (state ≠ IDLE)
- overrun  out  1  sticky: a frame tick arrived while busy
- clr_overrun  in  1  clears overrun

## Operation
- **Reset values:** all outputs 0. Counter is 0, pending mask is 0, state is IDLE.
- **Ticker:**
  - Counts while enable=1.
  - When count ≥ period, it emits a one-cycle tick and reloads 0; otherwise it increments.
  - When enable=0, count is held at 0 and no ticks are emitted.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - On tick, snapshot ch_enable into pending.
  - If the snapshot is non-zero, go to ISSUE with req_ch = lowest set bit.
  - If the snapshot is zero, stay in IDLE.
- **ISSUE:**
  - req_valid=1; req_ch is stable while req_valid is held.
  - On req_ready=1, go to WAIT.
  - If enable=0 in this state, deassert req_valid, go to IDLE, and clear pending.
- **WAIT:**
  - On rsp_valid=1, write rsp_data to slice req_ch, pulse out_strobe[req_ch], and clear pending[req_ch].
  - Then go to ISSUE with the next-lowest pending channel, or to IDLE if none remain (or if enable=0).
  - enable=0 in WAIT does not abort the outstanding transaction; its result is still written.
- **Overrun:**
  - A tick while state ≠ IDLE is dropped and sets overrun.
  - If set and clr_overrun occur in the same cycle, set wins.
- **Ignored inputs:**
  - rsp_valid in IDLE or ISSUE is ignored.
  - ch_enable changes mid-frame are ignored until the next tick.
- **Held values:** out_data holds its last value indefinitely; disable does not clear it.
- **Reset mid-operation:** return immediately to the reset values; out_data is cleared.

## Timing
- Tick asserts in the cycle where count ≥ period, so the frame length is period+1 cycles. period=0 ticks every cycle.
- Tick in cycle T → req_valid=1 in cycle T+1.
- Handshake completes in the cycle where req_valid & req_ready are both 1; the state is WAIT from the next cycle.
- rsp_valid in cycle R:
  - out_data and out_strobe update in R+1.
  - req_valid for the next channel asserts in R+1.
  - busy deasserts in R+1 if this was the last channel.
- Minimum cost per channel with zero-latency ready and response is 2 cycles. A full frame with k channels takes 2k cycles after T; ticks arriving within that window are overruns.
- A live period decrease below the current count causes a tick on the next cycle.

## Structure
- **Package pid_sched_pkg:**
  - State enum (IDLE, ISSUE, WAIT).
  - Pure function lowest_set(mask) returning the index and a found flag, used for both first and next channel selection.
- **Sub-module period_ticker:**
  - Ports: clk, reset_n, enable, period, tick.
  - Reused elsewhere for sample-rate generation.
- The top level holds the FSM, pending mask, the out_data registers and the overrun flag.

## Test plan
- **Basic frame:** reset, period=9, ch_enable=5'b10101, core ready at once, response 1 cycle later → requests ch0, ch2, ch4 in order; out_strobe pulses 00001, 00100, 10000; out_data slices equal the returned values; the frame repeats every 10 cycles.
- **Backpressure:** req_ready held low 4 cycles → req_valid and req_ch stay constant throughout; exactly one transaction completes.
- **Overrun:** period=2, ch_enable=5'b11111 → overrun=1 after the first frame. clr_overrun pulsed in the same cycle as a new overrun → overrun stays 1.
- **Disable mid-WAIT:** enable=0 while waiting on ch1 → the ch1 result is still latched; no further requests; busy=0; the counter holds at 0.
- **Async reset mid-ISSUE:** assert reset_n low between clock edges → req_valid, busy, out_data and overrun all go to 0 without waiting for a clock edge.
- **Empty mask and edges:** ch_enable=0 → ticks produce no requests and busy stays 0. Stray rsp_valid in IDLE → no out_strobe.
